// File: rtl/mem_ctrl.sv
// mem_ctrl: load/store unit bridging the EX stage to a request/response bus with timeout and misalignment faults
module mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_re,
    input  logic        ex_mem_we,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_rd_we,
    input  logic [4:0]  ex_rd_addr,
    input  logic [31:0] ex_rd_data,
    input  logic        flush_i,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        stall_o,
    output logic [1:0]  exc_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_unsigned;
    logic        r_load;
    logic        r_flush;
    logic [4:0]  r_rd_addr;

    logic        w_mem;
    logic        w_mis;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_done;
    logic        w_tout;
    logic [31:0] w_rsh;
    logic [31:0] w_ldata;

    // Size 11 behaves as a word everywhere, so only bit 1 distinguishes word accesses.
    assign w_mem   = ex_mem_re | ex_mem_we;
    assign w_mis   = (ex_size == 2'b01 && ex_addr[0]) || (ex_size[1] && ex_addr[1:0] != 2'b00);
    assign w_be    = ex_size[1] ? 4'b1111 : ((ex_size[0] ? 4'b0011 : 4'b0001) << ex_addr[1:0]);
    assign w_wdata = ex_size[1] ? ex_wdata : (ex_size[0] ? {2{ex_wdata[15:0]}} : {4{ex_wdata[7:0]}});
    assign w_done  = (r_state == S_RESP) && bus_rvalid;
    assign w_tout  = (r_state != S_IDLE) && !w_done && (r_cnt == 8'(TIMEOUT - 1));
    assign w_rsh   = bus_rdata >> {r_lane, 3'b000};
    assign w_ldata = r_size[1] ? bus_rdata :
                     r_size[0] ? {{16{!r_unsigned & w_rsh[15]}}, w_rsh[15:0]} :
                                 {{24{!r_unsigned & w_rsh[7]}}, w_rsh[7:0]};

    // Access FSM: accept in IDLE, hold the request until granted, wait for the response or time out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_size     <= 2'd0;
            r_lane     <= 2'd0;
            r_unsigned <= 1'b0;
            r_load     <= 1'b0;
            r_flush    <= 1'b0;
            r_rd_addr  <= 5'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_be     <= 4'd0;
            rd_we_o    <= 1'b0;
            rd_addr_o  <= 5'd0;
            rd_data_o  <= 32'd0;
            stall_o    <= 1'b0;
            exc_o      <= 2'b00;
        end else begin
            exc_o <= 2'b00;
            if (r_state == S_IDLE) begin
                if (ex_valid && w_mem) begin
                    rd_we_o <= 1'b0;
                    if (w_mis) begin
                        exc_o <= 2'b01;
                    end else begin
                        r_state    <= S_REQ;
                        r_cnt      <= 8'd0;
                        r_size     <= ex_size;
                        r_lane     <= ex_addr[1:0];
                        r_unsigned <= ex_unsigned;
                        r_load     <= ex_mem_re;
                        r_flush    <= 1'b0;
                        r_rd_addr  <= ex_rd_addr;
                        bus_req    <= 1'b1;
                        bus_we     <= ex_mem_we;
                        bus_addr   <= {ex_addr[31:2], 2'b00};
                        bus_wdata  <= w_wdata;
                        bus_be     <= w_be;
                        stall_o    <= 1'b1;
                    end
                end else if (ex_valid) begin
                    rd_we_o   <= ex_rd_we & !flush_i;
                    rd_addr_o <= ex_rd_addr;
                    rd_data_o <= ex_rd_data;
                end else begin
                    rd_we_o <= 1'b0;
                end
            end else begin
                rd_we_o <= 1'b0;
                r_flush <= r_flush | flush_i;
                r_cnt   <= r_cnt + 8'd1;
                if (w_done) begin
                    r_state <= S_IDLE;
                    stall_o <= 1'b0;
                    if (r_load) begin
                        rd_we_o   <= !(r_flush | flush_i);
                        rd_addr_o <= r_rd_addr;
                        rd_data_o <= w_ldata;
                    end
                end else if (w_tout) begin
                    r_state <= S_IDLE;
                    bus_req <= 1'b0;
                    stall_o <= 1'b0;
                    exc_o   <= 2'b10;
                end else if (r_state == S_REQ && bus_gnt) begin
                    bus_req <= 1'b0;
                    r_state <= S_RESP;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table, directed corner sequences and random transactions against a transaction-level model
module tb_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_mem_re = 1'b0, ex_mem_we = 1'b0, ex_unsigned = 1'b0;
    logic [1:0]  ex_size = 2'd0;
    logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0, ex_rd_data = 32'd0;
    logic        ex_rd_we = 1'b0;
    logic [4:0]  ex_rd_addr = 5'd0;
    logic        flush_i = 1'b0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        stall_o;
    logic [1:0]  exc_o;

    int n_chk = 0;
    int n_fail = 0;

    mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr), .ex_rd_data(ex_rd_data),
        .flush_i(flush_i),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .stall_o(stall_o), .exc_o(exc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, re, we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic        rwe;
        logic [4:0]  ra;
        logic [31:0] rdat;
        logic        fl;
        logic        e_we;
        logic [4:0]  e_ra;
        logic [31:0] e_rd;
        logic [1:0]  e_exc;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " bus_req"}, bus_req, 0);
        chk({nm, " bus_we"}, bus_we, 0);
        chk({nm, " bus_addr"}, bus_addr, 0);
        chk({nm, " bus_wdata"}, bus_wdata, 0);
        chk({nm, " bus_be"}, bus_be, 0);
        chk({nm, " rd_we"}, rd_we_o, 0);
        chk({nm, " rd_addr"}, rd_addr_o, 0);
        chk({nm, " rd_data"}, rd_data_o, 0);
        chk({nm, " stall"}, stall_o, 0);
        chk({nm, " exc"}, exc_o, 0);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input logic v, input logic we, input logic [4:0] ra, input logic [31:0] d, input logic fl);
        ex_valid = v; ex_mem_re = 0; ex_mem_we = 0;
        ex_rd_we = we; ex_rd_addr = ra; ex_rd_data = d; flush_i = fl;
        step();
        flush_i = 0;
        chk("alu rd_we", rd_we_o, v & we & !fl);
        chk("alu stall", stall_o, 0);
        if (v) begin
            chk("alu rd_addr", rd_addr_o, ra);
            chk("alu rd_data", rd_data_o, d);
        end
        ex_valid = 0;
    endtask

    // g: stall cycle in which gnt is given; r: cycles from grant to rvalid; f: stall cycle carrying flush (0 none)
    task automatic run_mem(input logic re, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic [4:0] rd, input int g, input int r, input int f, input bit noise);
        int nb, lane, n;
        bit mis, done, fl;
        logic [31:0] e_wd, e_ld, mask;
        logic [3:0]  e_be;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        lane = int'(addr[1:0]);
        mis  = (lane % nb) != 0;
        e_be = 4'(((1 << nb) - 1) << lane);
        for (int k = 0; k < 4; k++) e_wd[8*k +: 8] = wdata[8*(k % nb) +: 8];
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        e_ld = (rdata >> (8 * lane)) & mask;
        if (!uns && nb < 4 && e_ld[8*nb-1]) e_ld = e_ld | ~mask;
        done = (g + r) <= TO;
        n    = done ? g + r : TO;
        fl   = f >= 1 && f <= n;
        ex_valid = 1; ex_mem_re = re; ex_mem_we = !re; ex_size = size; ex_unsigned = uns;
        ex_addr = addr; ex_wdata = wdata; ex_rd_we = 1; ex_rd_addr = rd; ex_rd_data = $urandom;
        step();
        if (mis) begin
            ex_valid = 0;
            chk("mis exc", exc_o, 2'b01);
            chk("mis rd_we", rd_we_o, 0);
            chk("mis stall", stall_o, 0);
            chk("mis bus_req", bus_req, 0);
            step();
            chk("mis exc pulse", exc_o, 0);
            chk("mis bus_req after", bus_req, 0);
            return;
        end
        ex_mem_re = 0; ex_mem_we = 0;
        for (int c = 1; c <= n; c++) begin
            chk("mem stall", stall_o, 1);
            chk("mem bus_req", bus_req, c <= g);
            chk("mem rd_we", rd_we_o, 0);
            chk("mem exc", exc_o, 0);
            if (c == 1) begin
                chk("mem bus_addr", bus_addr, {addr[31:2], 2'b00});
                chk("mem bus_be", bus_be, e_be);
                chk("mem bus_we", bus_we, !re);
                chk("mem bus_wdata", bus_wdata, e_wd);
            end
            bus_gnt    = (c == g) || (noise && c > g && $urandom_range(1) == 1);
            bus_rvalid = (c == g + r) || (noise && c <= g && $urandom_range(1) == 1);
            bus_rdata  = (c == g + r) ? rdata : $urandom;
            flush_i    = (c == f);
            ex_rd_data = $urandom;
            step();
        end
        bus_gnt = 0; bus_rvalid = 0; flush_i = 0; ex_valid = 0;
        chk("end stall", stall_o, 0);
        chk("end bus_req", bus_req, 0);
        chk("end exc", exc_o, done ? 2'b00 : 2'b10);
        chk("end rd_we", rd_we_o, done && re && !fl);
        if (done && re && !fl) begin
            chk("load data", rd_data_o, e_ld);
            chk("load addr", rd_addr_o, rd);
        end
        step();
        chk("exc pulse", exc_o, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 0, 0, 2'd0, 32'h0,    1, 5'd5,  32'hDEADBEEF, 0, 1, 5'd5,  32'hDEADBEEF, 2'b00};
        tbl[1] = '{0, 0, 0, 2'd0, 32'h0,    1, 5'd7,  32'h11111111, 0, 0, 5'd5,  32'hDEADBEEF, 2'b00};
        tbl[2] = '{1, 1, 0, 2'd2, 32'h1,    1, 5'd3,  32'h0,        0, 0, 5'd5,  32'hDEADBEEF, 2'b01};
        tbl[3] = '{1, 0, 0, 2'd0, 32'h0,    1, 5'd9,  32'hCAFEF00D, 1, 0, 5'd9,  32'hCAFEF00D, 2'b00};
        tbl[4] = '{1, 0, 1, 2'd1, 32'h2003, 1, 5'd2,  32'h0,        0, 0, 5'd9,  32'hCAFEF00D, 2'b01};
        tbl[5] = '{1, 0, 0, 2'd0, 32'h0,    0, 5'd12, 32'h5,        0, 0, 5'd12, 32'h5,        2'b00};
        tbl[6] = '{1, 1, 0, 2'd3, 32'h2,    1, 5'd1,  32'h0,        0, 0, 5'd12, 32'h5,        2'b01};
        tbl[7] = '{1, 0, 0, 2'd0, 32'h0,    1, 5'd31, 32'hFFFFFFFF, 0, 1, 5'd31, 32'hFFFFFFFF, 2'b00};

        #2 rst = 1;
        #1 chk_zero("reset");
        step();
        rst = 0;

        for (int i = 0; i < 8; i++) begin
            ex_valid = tbl[i].v; ex_mem_re = tbl[i].re; ex_mem_we = tbl[i].we; ex_size = tbl[i].sz;
            ex_addr = tbl[i].addr; ex_rd_we = tbl[i].rwe; ex_rd_addr = tbl[i].ra;
            ex_rd_data = tbl[i].rdat; flush_i = tbl[i].fl;
            step();
            chk($sformatf("vec%0d rd_we", i), rd_we_o, tbl[i].e_we);
            chk($sformatf("vec%0d rd_addr", i), rd_addr_o, tbl[i].e_ra);
            chk($sformatf("vec%0d rd_data", i), rd_data_o, tbl[i].e_rd);
            chk($sformatf("vec%0d exc", i), exc_o, tbl[i].e_exc);
            chk($sformatf("vec%0d stall", i), stall_o, 0);
            chk($sformatf("vec%0d bus_req", i), bus_req, 0);
        end
        ex_valid = 0; flush_i = 0;
        step();

        run_mem(1, 2'd0, 0, 32'h1003, 32'h0, 32'h80000000, 5'd8, 3, 1, 0, 0);
        run_mem(0, 2'd1, 0, 32'h2002, 32'h1234, 32'h0, 5'd0, 1, 1, 0, 0);
        run_mem(1, 2'd2, 0, 32'h0001, 32'h0, 32'h0, 5'd1, 1, 1, 0, 0);
        run_mem(1, 2'd2, 0, 32'h3000, 32'h0, 32'h0, 5'd1, 99, 1, 0, 0);
        run_mem(1, 2'd2, 0, 32'h4000, 32'h0, 32'h12345678, 5'd2, 1, 2, 2, 0);
        run_mem(1, 2'd1, 1, 32'h5002, 32'h0, 32'h9ABC0000, 5'd3, 2, 1, 0, 0);
        run_alu(1, 1, 5'd5, 32'hDEADBEEF, 0);

        ex_valid = 1; ex_mem_re = 1; ex_mem_we = 0; ex_size = 2'd2; ex_addr = 32'h40;
        ex_wdata = 32'hA5A5A5A5; ex_rd_addr = 5'd4;
        step();
        ex_valid = 0; ex_mem_re = 0; bus_gnt = 1;
        step();
        bus_gnt = 0;
        chk("resp stall", stall_o, 1);
        #2 rst = 1;
        #1 chk_zero("async rst");
        step();
        chk_zero("held rst");
        rst = 0;
        run_alu(1, 1, 5'd6, 32'h0000600D, 0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(2) == 0)
                run_alu($urandom_range(3) != 0, 1'($urandom), 5'($urandom), $urandom, $urandom_range(3) == 0);
            else
                run_mem(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
                        $urandom_range(1, 4), $urandom_range(1, 2),
                        ($urandom_range(3) == 0) ? $urandom_range(1, 5) : 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
